aer_pingpong_bridge: RTL and testbench
======================================

# aer_pingpong_bridge

Streaming result-to-AER bridge, successor to the single-buffer bridge. It sits between the layer result stream and the spike router. Two ping-pong banks let frame N+1 load while frame N drains as spikes. Features: runtime threshold, short frames (early `i_last_result`), overflow detection, and an end-of-frame event that carries the emitted-spike count.

## Interface
- `NUM_INPUTS`, 64: bank depth (max words per frame), ≥2.
- `DATA_W`, 32: signed spike-time width.
- `CNT_W`, `$clog2(NUM_INPUTS+1)`: spike/length counter width, ≤ `DATA_W`.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_clk_enable` in 1: all state advances only when high; outputs hold otherwise.
- `i_t_max` in `DATA_W` (signed): emit threshold, latched per frame.
- `i_result_valid` in 1: upstream word valid.
- `i_result_data` in `DATA_W` (signed): spike time for current address.
- `i_last_result` in 1: marks final word of frame.
- `o_result_ready` in 1: out; upstream transfer occurs when valid & ready & enable at posedge.
- `o_req` out 1: downstream request, registered.
- `i_ack` in 1: downstream accept; transfer when `o_req & i_ack` at posedge.
- `o_req_type` out 1: 0 = spike, 1 = end-of-frame (EOF).
- `o_spike_time` out `DATA_W`: spike time, or zero-extended spike count on EOF.
- `o_spike_addr` out `$clog2(NUM_INPUTS)`: entry index; 0 on EOF.
- `o_done` out 1: one-cycle pulse after EOF accepted.
- `o_overflow` out 1: sticky; a frame exceeded `NUM_INPUTS` words.
- `o_busy` out 1: any bank full or draining.

## Operation
- **Reset values:** all outputs are 0. Both banks are empty. The write bank is bank 0.
- **Load side.**
  - Words are written to the write bank at index 0,1,…
  - The frame commits on a transfer with `i_last_result`. Commit stores the length (words written, capped at `NUM_INPUTS`) and `i_t_max` into the bank's registers, marks the bank full, and toggles the write bank.
  - Words beyond `NUM_INPUTS` are accepted and discarded until last; they set `o_overflow`.
  - `o_result_ready` = the write bank is not full.
- **Send FSM** states: `IDLE`, `SCAN`, `REQ`, `EOF`, `DONE`. It drains banks in commit order.
  - `IDLE`: when the read bank is full, go to `SCAN` with idx=0 and spike count=0.
  - `SCAN`: evaluate entry idx.
    - If `time < t_max` (signed compare), load the outputs and go to `REQ`.
    - Otherwise skip it; idx+1.
    - When idx = length, go to `EOF`.
  - `REQ`: hold `o_req=1`. On ack, count+1, idx+1, and return to `SCAN`.
  - `EOF`: `o_req=1`, `o_req_type=1`, `o_spike_time`=count. On ack, go to `DONE`.
  - `DONE`: pulse `o_done`, mark the read bank empty, toggle the read bank, go to `IDLE`.
- **Simultaneous events:**
  - A bank released in `DONE` may be written by the upstream transfer in the next cycle, not in the same cycle.
  - A commit to one bank and draining of the other proceed independently.
- **Zero-length frame:** impossible; every frame holds ≥1 word. A frame whose entries are all ≥ `t_max` sends only an EOF with count 0.
- **Reset mid-operation:** an in-flight request is dropped. No EOF is sent. Both banks are emptied and `o_overflow` clears.

## Timing
- A commit at edge k gives `SCAN` in cycle k+1.
- The first `o_req` rises at edge k+1+s, where s = entries skipped before the first kept entry.
- Each skipped entry costs 1 cycle.
- Each kept spike costs ≥2 cycles: `SCAN` + `REQ`; `REQ` extends until ack.
- `o_req` drops the cycle after the accepting edge. Back-to-back requests are therefore never adjacent.
- `o_spike_time` and `o_spike_addr` are stable while `o_req` is high.
- `o_done` is high the cycle after EOF ack. The next frame's `SCAN` is no earlier than the following cycle.
- The RAM read must present entry idx within the `SCAN` cycle: asynchronous or bypassed read.
- With `i_clk_enable` low, no counters, FSM or handshakes advance, and `o_req` holds.

## Structure
- **`aer_bridge_pkg`:**
  - send-FSM state enum;
  - `REQ_SPIKE=1'b0`, `REQ_EOF=1'b1`;
  - address/count width helper functions.
- **Sub-module `aer_pingpong_buf`:** two RAM banks, per-bank full flag, length and latched `t_max`. It has a write port with commit/bank toggle and a read port with release/bank toggle. The top level holds the load counter, overflow flag and send FSM.

## Test plan
Default configuration: `NUM_INPUTS=8`, `DATA_W=16`, `i_t_max=100`, `i_ack` tied high.
- **Full frame:** data 5,200,7,100,99,0,300,50 with last on word 8 → spikes (addr,time) (0,5),(2,7),(4,99),(5,0),(7,50), then EOF with time=5, then `o_done` pulse.
- **Short frame:** 3 words 1,2,3, last on word 3 → spikes at addr 0–2 only, EOF=3. Addr 3–7 are never sent.
- **Overlap:** frame B streamed while A drains with `i_ack` stalled 10 cycles per spike → B commits without waiting. A third frame sees `o_result_ready=0` until A's `DONE`. Spike order is all of A then all of B.
- **Overflow:** 11 words, last on word 11 → `o_overflow=1`, length 8, only the first 8 words are evaluated.
- **Threshold:** all data ≥ `i_t_max`, or `i_t_max=-32768` → EOF only, time=0. Changing `i_t_max` after commit does not affect that frame.
- **Reset and enable:** reset asserted during `REQ` → `o_req=0` immediately. After release, a new frame starts from bank 0. Toggling `i_clk_enable` low for 3 cycles during `REQ` → outputs hold, and timing stretches by exactly 3 cycles.

Source files
------------

// File: rtl/aer_pingpong_bridge_pkg.sv
// Shared types and width helpers for the ping-pong result-to-AER bridge.
package aer_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        REQ,
        EOF,
        DONE
    } send_state_t;

    localparam logic REQ_SPIKE = 1'b0;
    localparam logic REQ_EOF   = 1'b1;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One extra code point so a full bank's length (== n) is representable.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/aer_pingpong_bridge_if.sv
// Result stream (upstream) and AER request/ack (downstream) grouped as one bundle.
interface aer_pingpong_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic                     result_valid;
    logic signed [DATA_W-1:0] result_data;
    logic                     last_result;
    logic                     result_ready;
    logic                     req;
    logic                     ack;
    logic                     req_type;
    logic signed [DATA_W-1:0] spike_time;
    logic [ADDR_W-1:0]        spike_addr;

    modport slave (
        input  result_valid, result_data, last_result, ack,
        output result_ready, req, req_type, spike_time, spike_addr
    );

    modport master (
        output result_valid, result_data, last_result, ack,
        input  result_ready, req, req_type, spike_time, spike_addr
    );
endinterface

// File: rtl/aer_pingpong_buf.sv
// Two RAM banks with per-bank full flag, frame length and latched threshold.
module aer_pingpong_buf #(
    parameter int NUM_INPUTS = 64,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 7,
    parameter int ADDR_W     = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     commit,
    input  logic [CNT_W-1:0]         commit_len,
    input  logic signed [DATA_W-1:0] commit_t_max,
    input  logic                     release_bank,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     wr_full,
    output logic                     rd_avail,
    output logic                     any_full,
    output logic signed [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]         rd_len,
    output logic signed [DATA_W-1:0] rd_t_max
);
    logic signed [DATA_W-1:0] mem [2][NUM_INPUTS];
    logic                     wr_sel;
    logic                     rd_sel;
    logic [1:0]               full;
    logic [CNT_W-1:0]         len [2];
    logic signed [DATA_W-1:0] t_max [2];

    always_ff @(posedge clk) begin
        if (en && wr_en) mem[wr_sel][wr_addr] <= wr_data;
    end

    // Commit and release never target the same bank: one needs it empty, the other full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            len[0]   <= '0;
            len[1]   <= '0;
            t_max[0] <= '0;
            t_max[1] <= '0;
        end else if (en) begin
            if (commit) begin
                full[wr_sel]  <= 1'b1;
                len[wr_sel]   <= commit_len;
                t_max[wr_sel] <= commit_t_max;
                wr_sel        <= ~wr_sel;
            end
            if (release_bank) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end
        end
    end

    assign wr_full  = full[wr_sel];
    // Lookahead lets the sender start scanning the cycle right after a commit.
    assign rd_avail = full[rd_sel] | (commit & (wr_sel == rd_sel));
    assign any_full = |full;
    assign rd_data  = mem[rd_sel][rd_addr];
    assign rd_len   = len[rd_sel];
    assign rd_t_max = t_max[rd_sel];
endmodule

// File: rtl/aer_pingpong_bridge.sv
// Streams result frames into ping-pong banks and drains them as AER spikes plus an EOF count.
//   state | meaning
//   IDLE  | waiting for the read bank to fill
//   SCAN  | compare entry idx with the frame threshold
//   REQ   | spike request held until ack
//   EOF   | end-of-frame request carrying spike count
//   DONE  | o_done pulse, release read bank
module aer_pingpong_bridge
    import aer_bridge_pkg::*;
#(
    parameter int NUM_INPUTS = 64,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = cnt_width(NUM_INPUTS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clk_enable,
    input  logic signed [DATA_W-1:0] i_t_max,
    aer_pingpong_bridge_if.slave     bus,
    output logic                     o_done,
    output logic                     o_overflow,
    output logic                     o_busy
);
    localparam int ADDR_W = addr_width(NUM_INPUTS);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(NUM_INPUTS);

    send_state_t              state;
    logic [CNT_W-1:0]         load_cnt;
    logic [CNT_W-1:0]         idx;
    logic [CNT_W-1:0]         spike_cnt;
    logic                     ready_q;
    logic                     up_xfer;
    logic                     room;
    logic                     commit;
    logic                     release_bank;
    logic [CNT_W-1:0]         commit_len;
    logic                     wr_full;
    logic                     rd_avail;
    logic                     any_full;
    logic signed [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]         rd_len;
    logic signed [DATA_W-1:0] rd_t_max;

    // ready_q keeps o_result_ready low while in reset.
    assign bus.result_ready = ready_q & ~wr_full;
    assign up_xfer          = i_clk_enable & bus.result_valid & bus.result_ready;
    assign room             = (load_cnt != DEPTH);
    assign commit           = up_xfer & bus.last_result;
    assign commit_len       = room ? load_cnt + 1'b1 : DEPTH;
    assign release_bank     = i_clk_enable & (state == DONE);
    assign o_busy           = any_full | (state != IDLE);

    aer_pingpong_buf #(
        .NUM_INPUTS (NUM_INPUTS),
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .ADDR_W     (ADDR_W)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (i_clk_enable),
        .wr_en        (up_xfer & room),
        .wr_addr      (load_cnt[ADDR_W-1:0]),
        .wr_data      (bus.result_data),
        .commit       (commit),
        .commit_len   (commit_len),
        .commit_t_max (i_t_max),
        .release_bank (release_bank),
        .rd_addr      (idx[ADDR_W-1:0]),
        .wr_full      (wr_full),
        .rd_avail     (rd_avail),
        .any_full     (any_full),
        .rd_data      (rd_data),
        .rd_len       (rd_len),
        .rd_t_max     (rd_t_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt   <= '0;
            o_overflow <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (up_xfer) begin
                if (commit)    load_cnt <= '0;
                else if (room) load_cnt <= load_cnt + 1'b1;
                if (!room)     o_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            spike_cnt      <= '0;
            o_done         <= 1'b0;
            bus.req        <= 1'b0;
            bus.req_type   <= REQ_SPIKE;
            bus.spike_time <= '0;
            bus.spike_addr <= '0;
        end else if (i_clk_enable) begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: if (rd_avail) begin
                    idx       <= '0;
                    spike_cnt <= '0;
                    state     <= SCAN;
                end
                SCAN: if (idx == rd_len) begin
                    bus.req        <= 1'b1;
                    bus.req_type   <= REQ_EOF;
                    bus.spike_time <= DATA_W'(spike_cnt);
                    bus.spike_addr <= '0;
                    state          <= EOF;
                end else if (rd_data < rd_t_max) begin
                    bus.req        <= 1'b1;
                    bus.req_type   <= REQ_SPIKE;
                    bus.spike_time <= rd_data;
                    bus.spike_addr <= idx[ADDR_W-1:0];
                    state          <= REQ;
                end else begin
                    idx <= idx + 1'b1;
                end
                REQ: if (bus.ack) begin
                    bus.req   <= 1'b0;
                    spike_cnt <= spike_cnt + 1'b1;
                    idx       <= idx + 1'b1;
                    state     <= SCAN;
                end
                EOF: if (bus.ack) begin
                    bus.req        <= 1'b0;
                    bus.req_type   <= REQ_SPIKE;
                    bus.spike_time <= '0;
                    o_done         <= 1'b1;
                    state          <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aer_pingpong_bridge.sv
// Directed bench for aer_pingpong_bridge with NUM_INPUTS=8, DATA_W=16.
module tb_aer_pingpong_bridge;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = 3;
    typedef logic [AW+DW:0] entry_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b1;
    logic signed [DW-1:0] t_max = 16'sd100;
    logic                 o_done;
    logic                 o_overflow;
    logic                 o_busy;

    int     checks = 0;
    int     errors = 0;
    int     done_cnt = 0;
    int     wait_sum = 0;
    int     stall_cnt = 0;
    bit     stall_mode = 1'b0;
    entry_t q[$];
    entry_t exp_q[$];
    int     fa[8] = '{5, 200, 7, 100, 99, 0, 300, 50};

    aer_pingpong_bridge_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    aer_pingpong_bridge #(.NUM_INPUTS(N), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clk_enable (en),
        .i_t_max      (t_max),
        .bus          (bus),
        .o_done       (o_done),
        .o_overflow   (o_overflow),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!stall_mode) begin
            bus.ack = 1'b1;
            stall_cnt = 0;
        end else if (bus.req && !bus.ack) begin
            if (stall_cnt == 9) begin
                bus.ack = 1'b1;
                stall_cnt = 0;
            end else begin
                stall_cnt++;
            end
        end else begin
            bus.ack = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && en && bus.req && bus.ack)
            q.push_back({bus.req_type, bus.spike_addr, bus.spike_time});
        if (rst_n && en && o_done) done_cnt++;
    end

    function automatic entry_t ent(input int ty, input int a, input int t);
        entry_t e;
        e = {ty[0], a[AW-1:0], t[DW-1:0]};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag);
        chk({tag, "_count"}, 32'(q.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            chk(tag, (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        q.delete();
    endtask

    task automatic push(input int d, input bit last);
        int t = 0;
        while (!bus.result_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        wait_sum += t;
        chk("ready_before_push", 32'(bus.result_ready), 32'd1);
        bus.result_valid = 1'b1;
        bus.result_data  = d[DW-1:0];
        bus.last_result  = last;
        @(negedge clk);
        bus.result_valid = 1'b0;
        bus.last_result  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("done_count", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        bus.result_valid = 1'b0;
        bus.result_data  = '0;
        bus.last_result  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_req", 32'(bus.req), 32'd0);
        chk("rst_req_type", 32'(bus.req_type), 32'd0);
        chk("rst_spike_time", 32'(bus.spike_time), 32'd0);
        chk("rst_spike_addr", 32'(bus.spike_addr), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ready", 32'(bus.result_ready), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", 32'(bus.result_ready), 32'd1);

        // Full frame, with first-request latency
        foreach (fa[i]) push(fa[i], i == 7);
        chk("scan_cycle_req", 32'(bus.req), 32'd0);
        @(negedge clk);
        chk("first_req", 32'(bus.req), 32'd1);
        chk("first_time", 32'(bus.spike_time), 32'd5);
        chk("first_addr", 32'(bus.spike_addr), 32'd0);
        wait_done(1);
        exp_q = {ent(0,0,5), ent(0,2,7), ent(0,4,99), ent(0,5,0), ent(0,7,50), ent(1,0,5)};
        check_q("full_frame");
        chk("full_overflow", 32'(o_overflow), 32'd0);

        push(1, 1'b0); push(2, 1'b0); push(3, 1'b1);
        wait_done(2);
        exp_q = {ent(0,0,1), ent(0,1,2), ent(0,2,3), ent(1,0,3)};
        check_q("short_frame");

        push(100, 1'b0); push(150, 1'b0); push(32767, 1'b1);
        wait_done(3);
        exp_q = {ent(1,0,0)};
        check_q("all_above");

        t_max = -16'sd32768;
        push(-5, 1'b0); push(0, 1'b0); push(-32768, 1'b1);
        wait_done(4);
        exp_q = {ent(1,0,0)};
        check_q("min_tmax");

        t_max = 16'sd100;
        push(50, 1'b0); push(60, 1'b1);
        t_max = 16'sd10;
        wait_done(5);
        exp_q = {ent(0,0,50), ent(0,1,60), ent(1,0,2)};
        check_q("tmax_latched");
        t_max = 16'sd100;

        for (int i = 1; i <= 8; i++) push(i, 1'b0);
        chk("ovf_at_8", 32'(o_overflow), 32'd0);
        push(1, 1'b0);
        chk("ovf_at_9", 32'(o_overflow), 32'd1);
        push(1, 1'b0); push(1, 1'b1);
        wait_done(6);
        exp_q = {ent(0,0,1), ent(0,1,2), ent(0,2,3), ent(0,3,4), ent(0,4,5),
                 ent(0,5,6), ent(0,6,7), ent(0,7,8), ent(1,0,8)};
        check_q("overflow_frame");
        chk("ovf_sticky", 32'(o_overflow), 32'd1);

        // Overlap: B loads while A drains under a stalled ack
        stall_mode = 1'b1;
        wait_sum = 0;
        foreach (fa[i]) push(fa[i], i == 7);
        push(1, 1'b0); push(2, 1'b0); push(3, 1'b1);
        chk("b_no_wait", 32'(wait_sum), 32'd0);
        chk("both_full_ready", 32'(bus.result_ready), 32'd0);
        chk("a_not_done", 32'(done_cnt), 32'd6);
        push(7, 1'b1);
        chk("c_after_a_done", 32'(done_cnt), 32'd7);
        wait_done(9);
        stall_mode = 1'b0;
        repeat (2) @(negedge clk);
        exp_q = {ent(0,0,5), ent(0,2,7), ent(0,4,99), ent(0,5,0), ent(0,7,50), ent(1,0,5),
                 ent(0,0,1), ent(0,1,2), ent(0,2,3), ent(1,0,3),
                 ent(0,0,7), ent(1,0,1)};
        check_q("overlap_order");

        // Enable low for 3 cycles during REQ
        push(5, 1'b1);
        chk("en_scan", 32'(bus.req), 32'd0);
        @(negedge clk);
        chk("en_req", 32'(bus.req), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en_hold_req", 32'(bus.req), 32'd1);
            chk("en_hold_time", 32'(bus.spike_time), 32'd5);
        end
        en = 1'b1;
        @(negedge clk);
        chk("en_resume_scan", 32'(bus.req), 32'd0);
        @(negedge clk);
        chk("en_eof_req", 32'(bus.req), 32'd1);
        chk("en_eof_type", 32'(bus.req_type), 32'd1);
        chk("en_done_early", 32'(o_done), 32'd0);
        @(negedge clk);
        chk("en_done_pulse", 32'(o_done), 32'd1);
        @(negedge clk);
        chk("en_done_clear", 32'(o_done), 32'd0);
        exp_q = {ent(0,0,5), ent(1,0,1)};
        check_q("enable_frame");

        // Reset while a request is pending
        stall_mode = 1'b1;
        push(5, 1'b1);
        for (int t = 0; t < 50 && !bus.req; t++) @(negedge clk);
        chk("pre_rst_req", 32'(bus.req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.req), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_overflow", 32'(o_overflow), 32'd0);
        chk("mid_rst_ready", 32'(bus.result_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall_mode = 1'b0;
        repeat (3) @(negedge clk);
        push(9, 1'b1);
        wait_done(11);
        exp_q = {ent(0,0,9), ent(1,0,1)};
        check_q("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
